// File: rtl/program_memory_pkg.sv
// cpu_pkg: shared CPU widths, NOP encoding and program-memory FSM states
package cpu_pkg;
  localparam int CPU_DATA_W = 8;
  localparam int CPU_ADDR_W = 4;
  localparam logic [7:0] NOP = 8'h00;
  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;
endpackage

// File: rtl/program_memory_if.sv
// program_memory_if: fetch and byte-stream load bus between CPU/loader and program memory
interface program_memory_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
);
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              fetch_err;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              busy;
  logic [ADDR_W:0]   prog_len;
  modport master (
    output fetch_en, fetch_addr, ld_start, ld_valid, ld_data, ld_last,
    input  fetch_data, fetch_valid, fetch_err, ld_ready, busy, prog_len
  );
  modport slave (
    input  fetch_en, fetch_addr, ld_start, ld_valid, ld_data, ld_last,
    output fetch_data, fetch_valid, fetch_err, ld_ready, busy, prog_len
  );
endinterface

// File: rtl/program_memory_sync_ram.sv
// sync_ram: single write port, registered read port, no reset
module sync_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/program_memory.sv
// program_memory: RAM instruction store, cleared on reset and loaded from a byte stream
module program_memory
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DEPTH  = 16,
  parameter logic [DATA_W-1:0] FILL = DATA_W'(NOP)
) (
  input logic clk,
  input logic rst,
  program_memory_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DATA_W-1:0] wdata, rdata;
  logic pend, we, done, fetch, in_range, fill_q;
  always_comb begin
    state_n = state;
    we = 1'b0;
    wdata = FILL;
    done = 1'b0;
    unique case (state)
      CLEAR: begin
        we = 1'b1;
        done = wr_ptr == LAST;
        state_n = done ? RUN : CLEAR;
      end
      RUN: state_n = (bus.ld_start || pend) ? LOAD : RUN;
      LOAD: begin
        we = bus.ld_valid;
        wdata = bus.ld_data;
        done = bus.ld_valid && (bus.ld_last || wr_ptr == LAST);
        state_n = done ? RUN : LOAD;
      end
      default: state_n = CLEAR;
    endcase
  end
  assign fetch = bus.fetch_en && state == RUN;
  assign in_range = {1'b0, bus.fetch_addr} < (ADDR_W + 1)'(DEPTH);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      wr_ptr <= '0;
      pend <= 1'b0;
      bus.prog_len <= '0;
      bus.fetch_valid <= 1'b0;
      bus.fetch_err <= 1'b0;
      fill_q <= 1'b1;
    end else begin
      state <= state_n;
      wr_ptr <= (done || state == RUN) ? '0 : we ? wr_ptr + ADDR_W'(1) : wr_ptr;
      pend <= (state == CLEAR) && (pend || bus.ld_start);
      if (state == LOAD && done) bus.prog_len <= {1'b0, wr_ptr} + (ADDR_W + 1)'(1);
      bus.fetch_valid <= fetch;
      bus.fetch_err <= fetch && !in_range;
      // fill_q only moves on a served fetch so fetch_data holds between requests
      if (fetch) fill_q <= !in_range;
    end
  end
  assign bus.fetch_data = fill_q ? FILL : rdata;
  assign bus.ld_ready = state == LOAD;
  assign bus.busy = state != RUN;
  sync_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(wr_ptr),
    .wdata(wdata),
    .re(fetch && in_range),
    .raddr(bus.fetch_addr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_program_memory.sv
// tb_program_memory: directed checks of clear, fetch, load and reset behaviour
module tb_program_memory;
  logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  program_memory_if #(.DATA_W(8), .ADDR_W(4)) b1 ();
  program_memory_if #(.DATA_W(8), .ADDR_W(4)) b2 ();
  program_memory #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .FILL(8'h00)) dut (.clk(clk), .rst(rst), .bus(b1));
  program_memory #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .FILL(8'hEA)) dut2 (.clk(clk), .rst(rst2), .bus(b2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [3:0] a, input logic [7:0] d, input logic e);
    b1.fetch_en = 1'b1;
    b1.fetch_addr = a;
    tick();
    b1.fetch_en = 1'b0;
    chk("fetch_valid", b1.fetch_valid, 1);
    chk($sformatf("fetch_data[%0d]", a), b1.fetch_data, d);
    chk($sformatf("fetch_err[%0d]", a), b1.fetch_err, e);
  endtask

  task automatic load_start();
    b1.ld_start = 1'b1;
    tick();
    b1.ld_start = 1'b0;
    chk("ld_ready_after_start", b1.ld_ready, 1);
  endtask

  initial begin
    int n, n1, n2, nr;
    logic [7:0] words [4] = '{8'hAD, 8'hB6, 8'hC7, 8'h0A};
    logic       gv [6] = '{1, 0, 1, 0, 0, 1};
    logic [7:0] gd [6] = '{8'h11, 8'hFF, 8'h22, 8'hFF, 8'hFF, 8'h33};
    {b1.fetch_en, b1.fetch_addr, b1.ld_start, b1.ld_valid, b1.ld_data, b1.ld_last} = '0;
    {b2.fetch_en, b2.fetch_addr, b2.ld_start, b2.ld_valid, b2.ld_data, b2.ld_last} = '0;
    tick();
    tick();
    chk("rst_busy", b1.busy, 1);
    chk("rst_fetch_valid", b1.fetch_valid, 0);
    chk("rst_fetch_err", b1.fetch_err, 0);
    chk("rst_fetch_data", b1.fetch_data, 8'h00);
    chk("rst_ld_ready", b1.ld_ready, 0);
    chk("rst_prog_len", b1.prog_len, 0);
    chk("rst_fill_dut2", b2.fetch_data, 8'hEA);
    rst = 1'b0;
    rst2 = 1'b0;
    n1 = 0; n2 = 0; nr = 0;
    for (int i = 1; i <= 20; i++) begin
      b2.ld_start = (i == 3);
      tick();
      if (!b1.busy && n1 == 0) n1 = i;
      if (!b2.busy && n2 == 0) n2 = i;
      if (b2.ld_ready && nr == 0) nr = i;
    end
    b2.ld_start = 1'b0;
    chk("clear_cycles", n1, 16);
    chk("clear_cycles_dut2", n2, 12);
    chk("pending_load_dut2", nr, 13);
    for (int a = 0; a < 16; a++) fetch(4'(a), 8'h00, 1'b0);
    tick();
    chk("fetch_valid_pulse", b1.fetch_valid, 0);
    chk("fetch_data_hold", b1.fetch_data, 8'h00);
    load_start();
    chk("busy_in_load", b1.busy, 1);
    for (int i = 0; i < 4; i++) begin
      b1.ld_valid = 1'b1;
      b1.ld_data = words[i];
      b1.ld_last = (i == 3);
      tick();
    end
    {b1.ld_valid, b1.ld_last} = '0;
    chk("load1_busy", b1.busy, 0);
    chk("load1_ready", b1.ld_ready, 0);
    chk("load1_len", b1.prog_len, 4);
    for (int a = 0; a < 4; a++) fetch(4'(a), words[a], 1'b0);
    fetch(4'd4, 8'h00, 1'b0);
    load_start();
    for (int i = 0; i < 6; i++) begin
      b1.ld_valid = gv[i];
      b1.ld_data = gd[i];
      b1.ld_last = (i == 5);
      chk("gap_ready", b1.ld_ready, 1);
      tick();
    end
    {b1.ld_valid, b1.ld_last} = '0;
    chk("gap_len", b1.prog_len, 3);
    fetch(4'd0, 8'h11, 1'b0);
    fetch(4'd1, 8'h22, 1'b0);
    fetch(4'd2, 8'h33, 1'b0);
    fetch(4'd3, 8'h0A, 1'b0);
    load_start();
    for (int i = 0; i < 20; i++) begin
      b1.ld_valid = 1'b1;
      b1.ld_data = 8'(8'h40 + i);
      chk($sformatf("ovf_ready[%0d]", i), b1.ld_ready, i < 16);
      tick();
    end
    b1.ld_valid = 1'b0;
    chk("ovf_len", b1.prog_len, 16);
    fetch(4'd15, 8'h4F, 1'b0);
    fetch(4'd0, 8'h40, 1'b0);
    load_start();
    b1.ld_valid = 1'b1;
    b1.ld_data = 8'h99;
    tick();
    b1.ld_data = 8'h98;
    tick();
    b1.ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midload_rst_len", b1.prog_len, 0);
    chk("midload_rst_busy", b1.busy, 1);
    rst = 1'b0;
    b1.fetch_en = 1'b1;
    b1.fetch_addr = 4'd0;
    tick();
    b1.fetch_en = 1'b0;
    chk("fetch_dropped_busy", b1.fetch_valid, 0);
    n = 1;
    while (b1.busy && n < 40) begin
      tick();
      n++;
    end
    chk("reclear_cycles", n, 16);
    fetch(4'd0, 8'h00, 1'b0);
    fetch(4'd1, 8'h00, 1'b0);
    fetch(4'd5, 8'h00, 1'b0);
    b2.ld_valid = 1'b1;
    b2.ld_data = 8'h5A;
    b2.ld_last = 1'b1;
    tick();
    {b2.ld_valid, b2.ld_last} = '0;
    chk("dut2_busy", b2.busy, 0);
    chk("dut2_len", b2.prog_len, 1);
    b2.fetch_en = 1'b1;
    b2.fetch_addr = 4'd13;
    tick();
    chk("dut2_oor_valid", b2.fetch_valid, 1);
    chk("dut2_oor_data", b2.fetch_data, 8'hEA);
    chk("dut2_oor_err", b2.fetch_err, 1);
    b2.fetch_addr = 4'd0;
    tick();
    chk("dut2_word0", b2.fetch_data, 8'h5A);
    chk("dut2_word0_err", b2.fetch_err, 0);
    b2.fetch_addr = 4'd11;
    tick();
    b2.fetch_en = 1'b0;
    chk("dut2_word11", b2.fetch_data, 8'hEA);
    chk("dut2_word11_err", b2.fetch_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
